// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction unit.
// Tags are held zero-extended so one entry type serves any BTB size.
package bp_pkg;

  localparam int BP_XLEN = 32;
  localparam int BP_CTR_W = 2;

  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
  } btb_entry_t;

  function automatic int ctr_init(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CTR_INIT = ctr_init(BP_CTR_W);
  localparam int CTR_MAX = ctr_max(BP_CTR_W);

endpackage

// File: rtl/bht_table.sv
// Branch history table: saturating counters, one async read port,
// one clocked update port, full async reset to weakly not-taken.
module bht_table
  import bp_pkg::*;
#(
  parameter int BHT_IDX_W = 8,
  parameter int CTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0]     o_rd_ctr,
  input  logic                 i_wr_en,
  input  logic [BHT_IDX_W-1:0] i_wr_idx,
  input  logic                 i_wr_taken
);

  localparam int N = 1 << BHT_IDX_W;
  localparam logic [CTR_W-1:0] L_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] L_MAX = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] L_ONE = CTR_W'(1);

  logic [CTR_W-1:0] r_ctr [N];
  logic [CTR_W-1:0] w_cur;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur = r_ctr[i_wr_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_ctr[i] <= L_INIT;
      end
    end else if (i_wr_en) begin
      if (i_wr_taken) begin
        if (w_cur != L_MAX) r_ctr[i_wr_idx] <= w_cur + L_ONE;
      end else begin
        if (w_cur != '0) r_ctr[i_wr_idx] <= w_cur - L_ONE;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Next-PC unit: BTB + BHT lookup on the IF PC, training and
// misprediction detection from EX, PC select and branch statistics.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN = BP_XLEN,
  parameter int BTB_IDX_W = 6,
  parameter int BHT_IDX_W = 8,
  parameter int CTR_W = BP_CTR_W,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc_f,
  input  logic [XLEN-1:0]   pc_e,
  input  logic              jal_d,
  input  logic [XLEN-1:0]   jal_target_d,
  input  logic              jalr_e,
  input  logic [XLEN-1:0]   jalr_target_e,
  input  logic              br_inst_e,
  input  logic              branch_taken_e,
  input  logic [XLEN-1:0]   branch_target_e,
  input  logic              pred_taken_e,
  input  logic [XLEN-1:0]   pred_target_e,
  output logic              pred_taken_f,
  output logic [XLEN-1:0]   pred_target_f,
  output logic              mispredict_e,
  output logic [XLEN-1:0]   pc_in,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TSH = BTB_IDX_W + 2;
  localparam logic [XLEN-1:0] L_FOUR = XLEN'(4);
  localparam logic [STAT_W-1:0] L_SONE = STAT_W'(1);

  btb_entry_t r_btb [BTB_N];
  logic [STAT_W-1:0] r_stat_b;
  logic [STAT_W-1:0] r_stat_m;

  logic [BTB_IDX_W-1:0] w_idx_f;
  logic [BTB_IDX_W-1:0] w_idx_e;
  logic [XLEN-1:0]      w_tag_f;
  logic [XLEN-1:0]      w_tag_e;
  btb_entry_t           w_ent_f;
  logic                 w_hit;
  logic [CTR_W-1:0]     w_ctr_f;
  logic [XLEN-1:0]      w_pc4_f;
  logic [XLEN-1:0]      w_pc4_e;
  logic                 w_dir_bad;
  logic                 w_tgt_bad;

  assign w_idx_f = pc_f[BTB_IDX_W+1:2];
  assign w_idx_e = pc_e[BTB_IDX_W+1:2];
  assign w_tag_f = pc_f >> TSH;
  assign w_tag_e = pc_e >> TSH;
  assign w_ent_f = r_btb[w_idx_f];
  assign w_hit = w_ent_f.valid && (w_ent_f.tag == w_tag_f);
  assign w_pc4_f = pc_f + L_FOUR;
  assign w_pc4_e = pc_e + L_FOUR;

  bht_table #(
    .BHT_IDX_W(BHT_IDX_W),
    .CTR_W(CTR_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_idx  (pc_f[BHT_IDX_W+1:2]),
    .o_rd_ctr  (w_ctr_f),
    .i_wr_en   (br_inst_e),
    .i_wr_idx  (pc_e[BHT_IDX_W+1:2]),
    .i_wr_taken(branch_taken_e)
  );

  assign pred_taken_f = w_hit & w_ctr_f[CTR_W-1];
  assign pred_target_f = w_hit ? w_ent_f.target : w_pc4_f;

  assign w_dir_bad = branch_taken_e != pred_taken_e;
  assign w_tgt_bad = branch_taken_e & pred_taken_e &
                     (pred_target_e != branch_target_e);
  assign mispredict_e = br_inst_e & (w_dir_bad | w_tgt_bad);

  always_comb begin
    pc_in = w_pc4_f;
    priority case (1'b1)
      jalr_e:       pc_in = jalr_target_e;
      mispredict_e: pc_in = branch_taken_e ? branch_target_e : w_pc4_e;
      jal_d:        pc_in = jal_target_d;
      pred_taken_f: pc_in = pred_target_f;
      default:      pc_in = w_pc4_f;
    endcase
  end

  // Only taken branches allocate; a new tag simply evicts any alias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        r_btb[i] <= '0;
      end
    end else if (br_inst_e && branch_taken_e) begin
      r_btb[w_idx_e].valid <= 1'b1;
      r_btb[w_idx_e].tag <= w_tag_e;
      r_btb[w_idx_e].target <= branch_target_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_b <= '0;
      r_stat_m <= '0;
    end else begin
      if (br_inst_e && r_stat_b != '1) r_stat_b <= r_stat_b + L_SONE;
      if (mispredict_e && r_stat_m != '1) r_stat_m <= r_stat_m + L_SONE;
    end
  end

  assign stat_branches = r_stat_b;
  assign stat_mispredicts = r_stat_m;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table plus
// hand-written reset and statistics saturation sequences.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f = 32'h0;
  logic [31:0] pc_e = 32'h0;
  logic        jal_d = 1'b0;
  logic [31:0] jal_target_d = 32'h0;
  logic        jalr_e = 1'b0;
  logic [31:0] jalr_target_e = 32'h0;
  logic        br_inst_e = 1'b0;
  logic        branch_taken_e = 1'b0;
  logic [31:0] branch_target_e = 32'h0;
  logic        pred_taken_e = 1'b0;
  logic [31:0] pred_target_e = 32'h0;

  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        mispredict_e;
  logic [31:0] pc_in;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  logic        s_pred_taken_f;
  logic [31:0] s_pred_target_f;
  logic        s_mispredict_e;
  logic [31:0] s_pc_in;
  logic [3:0]  s_stat_b;
  logic [3:0]  s_stat_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pc_e(pc_e),
    .jal_d(jal_d), .jal_target_d(jal_target_d),
    .jalr_e(jalr_e), .jalr_target_e(jalr_target_e),
    .br_inst_e(br_inst_e), .branch_taken_e(branch_taken_e),
    .branch_target_e(branch_target_e),
    .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .mispredict_e(mispredict_e), .pc_in(pc_in),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  branch_predict_unit #(.STAT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pc_e(pc_e),
    .jal_d(jal_d), .jal_target_d(jal_target_d),
    .jalr_e(jalr_e), .jalr_target_e(jalr_target_e),
    .br_inst_e(br_inst_e), .branch_taken_e(branch_taken_e),
    .branch_target_e(branch_target_e),
    .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
    .pred_taken_f(s_pred_taken_f), .pred_target_f(s_pred_target_f),
    .mispredict_e(s_mispredict_e), .pc_in(s_pc_in),
    .stat_branches(s_stat_b),
    .stat_mispredicts(s_stat_m)
  );

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pce;
    logic        jal;
    logic [31:0] jalt;
    logic        jalr;
    logic [31:0] jalrt;
    logic        br;
    logic        tk;
    logic [31:0] btgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_pcin;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    pc_e = 32'h0; jal_d = 1'b0; jal_target_d = 32'h0;
    jalr_e = 1'b0; jalr_target_e = 32'h0;
    br_inst_e = 1'b0; branch_taken_e = 1'b0;
    branch_target_e = 32'h0; pred_taken_e = 1'b0;
    pred_target_e = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h104, 0, 32'h104};
    vecs[1]  = '{32'h200, 32'h200, 0, 0, 0, 0, 1, 1, 32'h280, 0, 32'h204,
                 0, 32'h204, 1, 32'h280};
    vecs[2]  = '{32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h280, 0, 32'h280};
    vecs[3]  = '{32'h100, 32'h200, 0, 0, 0, 0, 1, 1, 32'h280, 1, 32'h280,
                 0, 32'h104, 0, 32'h104};
    vecs[4]  = '{32'h100, 32'h200, 0, 0, 0, 0, 1, 1, 32'h280, 1, 32'h280,
                 0, 32'h104, 0, 32'h104};
    vecs[5]  = '{32'h200, 32'h200, 0, 0, 0, 0, 1, 0, 32'h280, 1, 32'h280,
                 1, 32'h280, 1, 32'h204};
    vecs[6]  = '{32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h280, 0, 32'h280};
    vecs[7]  = '{32'h200, 32'h200, 0, 0, 0, 0, 1, 1, 32'h300, 1, 32'h280,
                 1, 32'h280, 1, 32'h300};
    vecs[8]  = '{32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h300, 0, 32'h300};
    vecs[9]  = '{32'h200, 32'h500, 1, 32'h600, 1, 32'h400, 1, 0, 32'h580,
                 1, 32'h580, 1, 32'h300, 1, 32'h400};
    vecs[10] = '{32'h200, 32'h500, 1, 32'h600, 0, 32'h400, 1, 0, 32'h580,
                 1, 32'h580, 1, 32'h300, 1, 32'h504};
    vecs[11] = '{32'h200, 0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h300, 0, 32'h600};
    vecs[12] = '{32'h200, 32'h300, 0, 0, 0, 0, 1, 1, 32'h380, 0, 32'h304,
                 1, 32'h300, 1, 32'h380};
    vecs[13] = '{32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h204, 0, 32'h204};
    vecs[14] = '{32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h380, 0, 32'h380};
    vecs[15] = '{32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h0, 0, 32'h0};
    vecs[16] = '{32'h100, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 32'h10, 1, 32'h10,
                 0, 32'h104, 1, 32'h0};
    vecs[17] = '{32'h100, 32'h300, 0, 0, 0, 0, 1, 1, 32'h380, 1, 32'h380,
                 0, 32'h104, 0, 32'h104};
    vecs[18] = '{32'h100, 32'h500, 0, 0, 0, 0, 1, 0, 32'h580, 0, 32'h508,
                 0, 32'h104, 0, 32'h104};

    idle();
    pc_f = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stat_b", stat_branches, 32'd0);
    chk("reset_stat_m", stat_mispredicts, 32'd0);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 19; i++) begin
      pc_f = vecs[i].pcf;
      pc_e = vecs[i].pce;
      jal_d = vecs[i].jal;
      jal_target_d = vecs[i].jalt;
      jalr_e = vecs[i].jalr;
      jalr_target_e = vecs[i].jalrt;
      br_inst_e = vecs[i].br;
      branch_taken_e = vecs[i].tk;
      branch_target_e = vecs[i].btgt;
      pred_taken_e = vecs[i].ptk;
      pred_target_e = vecs[i].ptgt;
      #1;
      chk($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken_f},
          {31'b0, vecs[i].e_pt});
      chk($sformatf("v%0d_pred_target", i), pred_target_f,
          vecs[i].e_ptgt);
      chk($sformatf("v%0d_mispredict", i), {31'b0, mispredict_e},
          {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_pc_in", i), pc_in, vecs[i].e_pcin);
      tick();
    end
    idle();
    #1;
    chk("stat_b_after_table", stat_branches, 32'd11);
    chk("stat_m_after_table", stat_mispredicts, 32'd7);
    chk("small_stat_b_after_table", {28'b0, s_stat_b}, 32'd11);
    chk("small_stat_m_after_table", {28'b0, s_stat_m}, 32'd7);

    // Asynchronous reset between edges clears tables and stats at once.
    pc_f = 32'h300;
    #1;
    chk("pre_reset_hit", {31'b0, pred_taken_f}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pred", {31'b0, pred_taken_f}, 32'd0);
    chk("async_reset_target", pred_target_f, 32'h304);
    chk("async_reset_pc_in", pc_in, 32'h304);
    chk("async_reset_stat_b", stat_branches, 32'd0);
    chk("async_reset_stat_m", stat_mispredicts, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Every cycle a direction mispredict: both counters move together.
    pc_f = 32'h100;
    pc_e = 32'h700;
    br_inst_e = 1'b1;
    branch_taken_e = 1'b0;
    pred_taken_e = 1'b1;
    pred_target_e = 32'h780;
    repeat (15) tick();
    chk("sat_small_b_15", {28'b0, s_stat_b}, 32'd15);
    chk("sat_small_m_15", {28'b0, s_stat_m}, 32'd15);
    tick();
    chk("sat_small_b_hold", {28'b0, s_stat_b}, 32'd15);
    chk("sat_small_m_hold", {28'b0, s_stat_m}, 32'd15);
    chk("sat_big_b_16", stat_branches, 32'd16);
    chk("sat_big_m_16", stat_mispredicts, 32'd16);
    idle();
    tick();
    chk("sat_small_b_idle", {28'b0, s_stat_b}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
